aes_encrypt_core: RTL and testbench

- Iterative AES-128 encryption engine; the forward-direction counterpart of the existing decryption round logic.
- Takes a 128-bit plaintext and a precomputed 11-entry key schedule. Runs the initial AddRoundKey, then 10 rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey, with MixColumns skipped in round 10.
- Shares one external 4-byte-wide S-box with the rest of the design: one state column is substituted per cycle.
- Sits between the key expansion unit and the bus-side register interface.

---
 rtl/aes_encrypt_core.sv | 165 ++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one S-box column per cycle through a shared external S-box.
// Latency 52 cycles from accepted start to done; start is ignored while busy.
module aes_encrypt_core #(
  parameter int ROUNDS = 10
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [127:0]                plaintext,
  input  logic [128*(ROUNDS+1)-1:0]   key_schedule,
  output logic [31:0]                 sub_in,
  input  logic [31:0]                 sub_out,
  output logic [127:0]                ciphertext,
  output logic                        busy,
  output logic                        done
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    SUB  = 3'd2,
    MIX  = 3'd3,
    DONE = 3'd4
  } fsm_t;

  fsm_t         fsm_q;
  fsm_t         fsm_d;
  logic [127:0] aes_state;
  logic [3:0]   round;
  logic [1:0]   col;

  logic [127:0] round_key [0:ROUNDS];
  logic [127:0] rk;
  logic [127:0] shifted;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Output byte s'[r][c] takes s[r][(c+r) mod 4]: row r rotated left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Round key k sits in the k-th 128-bit slice counted from the MSB end.
  always_comb begin
    for (int k = 0; k <= ROUNDS; k++) begin
      round_key[k] = key_schedule[128*(ROUNDS-k) +: 128];
    end
  end

  assign rk        = round_key[round];
  assign shifted   = shift_rows(aes_state);
  assign round_out = (round == LAST_ROUND) ? (shifted ^ rk)
                                           : (mix_columns(shifted) ^ rk);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    busy   = 1'b0;
    done   = 1'b0;
    sub_in = '0;
    case (fsm_q)
      IDLE: begin
        if (start) fsm_d = INIT;
      end
      INIT: begin
        busy  = 1'b1;
        fsm_d = SUB;
      end
      SUB: begin
        busy   = 1'b1;
        // ~col picks slice 3-col, i.e. column 0 is the top word.
        sub_in = aes_state[{~col, 5'b0} +: 32];
        if (col == 2'd3) fsm_d = MIX;
      end
      MIX: begin
        busy  = 1'b1;
        fsm_d = (round == LAST_ROUND) ? DONE : SUB;
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = start ? INIT : IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      aes_state  <= '0;
      ciphertext <= '0;
      round      <= '0;
      col        <= '0;
    end else begin
      case (fsm_q)
        IDLE, DONE: begin
          if (start) begin
            aes_state <= plaintext;
            round     <= 4'd1;
          end
        end
        INIT: begin
          aes_state <= aes_state ^ round_key[0];
          col       <= 2'd0;
        end
        SUB: begin
          aes_state[{~col, 5'b0} +: 32] <= sub_out;
          col                           <= col + 2'd1;
        end
        MIX: begin
          aes_state <= round_out;
          if (round == LAST_ROUND) begin
            ciphertext <= round_out;
          end else begin
            round <= round + 4'd1;
            col   <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core against FIPS-197 vectors, with a behavioural S-box on the sub port.
module tb_aes_encrypt_core;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [127:0]  plaintext;
  logic [1407:0] key_schedule;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [127:0]  ciphertext;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] sub_log  [0:127];
  logic        busy_log [0:127];
  logic        done_log [0:127];
  logic [1407:0] ks_c1;
  logic [1407:0] ks_b;

  aes_encrypt_core #(.ROUNDS(10)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .plaintext    (plaintext),
    .key_schedule (key_schedule),
    .sub_in       (sub_in),
    .sub_out      (sub_out),
    .ciphertext   (ciphertext),
    .busy         (busy),
    .done         (done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign sub_out = sub_word(sub_in);

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rcon;
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (cyc < 128) begin
      sub_log[cyc]  = sub_in;
      busy_log[cyc] = busy;
      done_log[cyc] = done;
    end
  endtask

  // Cycle 1 is the cycle after the edge that accepts start.
  task automatic begin_run(input logic [127:0] pt, input logic [1407:0] ks);
    @(negedge Clk);
    plaintext    = pt;
    key_schedule = ks;
    start        = 1'b1;
    cyc          = 0;
    for (int i = 0; i < 128; i++) begin
      sub_log[i]  = '0;
      busy_log[i] = 1'b0;
      done_log[i] = 1'b0;
    end
  endtask

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_done(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (done_log[i] === 1'b1) return i;
    return 0;
  endfunction

  initial begin
    int busy_bad;
    ks_c1 = expand_key(KEY_C1);
    ks_b  = expand_key(KEY_B);
    Reset = 1'b1;
    start = 1'b0;
    plaintext    = '0;
    key_schedule = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk_eq("rst_busy", 128'(busy), 0);
    chk_eq("rst_done", 128'(done), 0);
    chk_eq("rst_sub_in", 128'(sub_in), 0);
    chk_eq("rst_ct", ciphertext, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // C.1 single block
    begin_run(PT_C1, ks_c1);
    step();
    start = 1'b0;
    while (cyc < 56) step();
    chk_eq("c1_done_cyc", 128'(first_done(1, 56)), 52);
    chk_eq("c1_done_cnt", 128'(count_done(1, 56)), 1);
    chk_eq("c1_ct", ciphertext, CT_C1);
    busy_bad = 0;
    for (int i = 1; i <= 56; i++) if (busy_log[i] !== (i <= 51)) busy_bad++;
    chk_eq("c1_busy_profile", 128'(busy_bad), 0);
    chk_eq("c1_sub_init", 128'(sub_log[1]), 0);
    chk_eq("c1_sub_c0", 128'(sub_log[2]), 128'h00102030);
    chk_eq("c1_sub_c1", 128'(sub_log[3]), 128'h40506070);
    chk_eq("c1_sub_c2", 128'(sub_log[4]), 128'h8090a0b0);
    chk_eq("c1_sub_c3", 128'(sub_log[5]), 128'hc0d0e0f0);
    chk_eq("c1_sub_mix", 128'(sub_log[6]), 0);
    chk_eq("c1_sub_done", 128'(sub_log[52]), 0);

    // Appendix B, round-1 state seen as the round-2 S-box columns
    begin_run(PT_B, ks_b);
    step();
    start = 1'b0;
    while (cyc < 56) step();
    chk_eq("b_r1_c0", 128'(sub_log[7]),  128'ha49c7ff2);
    chk_eq("b_r1_c1", 128'(sub_log[8]),  128'h689f352b);
    chk_eq("b_r1_c2", 128'(sub_log[9]),  128'h6b5bea43);
    chk_eq("b_r1_c3", 128'(sub_log[10]), 128'h026a5049);
    chk_eq("b_done_cyc", 128'(first_done(1, 56)), 52);
    chk_eq("b_ct", ciphertext, CT_B);

    // Back-to-back with start held, inputs switched in the DONE cycle
    begin_run(PT_C1, ks_c1);
    while (cyc < 110) begin
      step();
      if (cyc == 52) begin
        chk_eq("b2b_ct1", ciphertext, CT_C1);
        plaintext    = PT_B;
        key_schedule = ks_b;
      end
      if (cyc == 53) start = 1'b0;
      if (cyc == 80) chk_eq("b2b_ct1_held", ciphertext, CT_C1);
    end
    chk_eq("b2b_first", 128'(first_done(1, 110)), 52);
    chk_eq("b2b_second", 128'(first_done(53, 110)), 104);
    chk_eq("b2b_done_cnt", 128'(count_done(1, 110)), 2);
    chk_eq("b2b_ct2_held", ciphertext, CT_B);

    // Start pulse and plaintext change mid-flight must be ignored
    begin_run(PT_C1, ks_c1);
    step();
    start = 1'b0;
    while (cyc < 60) begin
      step();
      if (cyc == 20) begin
        start     = 1'b1;
        plaintext = '1;
      end
      if (cyc == 21) start = 1'b0;
    end
    chk_eq("ign_done_cyc", 128'(first_done(1, 60)), 52);
    chk_eq("ign_done_cnt", 128'(count_done(1, 60)), 1);
    chk_eq("ign_ct", ciphertext, CT_C1);

    // Reset in the middle of a block
    begin_run(PT_C1, ks_c1);
    step();
    start = 1'b0;
    while (cyc < 30) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk_eq("mid_rst_busy", 128'(busy), 0);
    chk_eq("mid_rst_done", 128'(done), 0);
    chk_eq("mid_rst_ct", ciphertext, 0);
    while (cyc < 40) step();
    chk_eq("mid_rst_no_done", 128'(count_done(31, 40)), 0);
    begin_run(PT_C1, ks_c1);
    step();
    start = 1'b0;
    while (cyc < 56) step();
    chk_eq("post_rst_done_cyc", 128'(first_done(1, 56)), 52);
    chk_eq("post_rst_ct", ciphertext, CT_C1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
